// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, RV32I opcode constants and the issue entry
// carried from decode to the execute stage.
package alu_pkg;

  localparam int unsigned ISSUE_XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [ISSUE_XLEN-1:0] d1;
    logic [ISSUE_XLEN-1:0] d2;
    alu_op_t               control;
    logic [4:0]            rd;
    logic                  wen;
    logic                  illegal;
    logic [ISSUE_XLEN-1:0] pc;
  } issue_entry_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decoder (OP, OP-IMM, LUI, AUIPC) producing one issue
// entry: ALU control code, operands, destination and legality.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0]           instr_i,
  input  logic [ISSUE_XLEN-1:0] pc_i,
  input  logic [ISSUE_XLEN-1:0] rs1_i,
  input  logic [ISSUE_XLEN-1:0] rs2_i,
  output issue_entry_t          entry_o
);

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [ISSUE_XLEN-1:0] i_imm;
  logic [ISSUE_XLEN-1:0] u_imm;
  logic [ISSUE_XLEN-1:0] shamt;
  logic                  legal;
  logic [3:0]            ctrl;
  logic [ISSUE_XLEN-1:0] d1;
  logic [ISSUE_XLEN-1:0] d2;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign i_imm  = {{(ISSUE_XLEN-12){instr_i[31]}}, instr_i[31:20]};
  assign u_imm  = {instr_i[31:12], 12'b0};
  assign shamt  = {{(ISSUE_XLEN-5){1'b0}}, instr_i[24:20]};

  always_comb begin
    legal = 1'b0;
    ctrl  = ALU_ADD;
    d1    = '0;
    d2    = '0;
    unique case (opcode)
      OPC_OP: begin
        legal = (funct7 == 7'b0000000) ||
                ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        ctrl  = {instr_i[30], funct3};
        d1    = rs1_i;
        d2    = rs2_i;
      end
      OPC_OP_IMM: begin
        legal = 1'b1;
        ctrl  = {1'b0, funct3};
        d1    = rs1_i;
        d2    = i_imm;
        // Shifts carry only the shift amount, so funct7 bits never leak into d2.
        if (funct3 == 3'b001) begin
          legal = (funct7 == 7'b0000000);
          d2    = shamt;
        end else if (funct3 == 3'b101) begin
          legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          ctrl  = instr_i[30] ? ALU_SRA : ALU_SRL;
          d2    = shamt;
        end
      end
      OPC_LUI: begin
        legal = 1'b1;
        d2    = u_imm;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        d1    = pc_i;
        d2    = u_imm;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    entry_o         = '0;
    entry_o.rd      = instr_i[11:7];
    entry_o.pc      = pc_i;
    entry_o.control = ALU_ADD;
    if (legal) begin
      entry_o.d1      = d1;
      entry_o.d2      = d2;
      entry_o.control = alu_op_t'(ctrl);
      entry_o.wen     = (instr_i[11:7] != 5'd0);
    end else begin
      entry_o.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode plus a 2-entry skid buffer between two valid/ready
// handshakes. Define ALU_ISSUE_STATS_EN to add stat_issued/stat_illegal counters.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN   = ISSUE_XLEN,
  parameter int unsigned STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_d1,
  output logic [XLEN-1:0]   out_d2,
  output logic [3:0]        out_control,
  output logic [4:0]        out_rd,
  output logic              out_wen,
  output logic              out_illegal,
  output logic [XLEN-1:0]   out_pc
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_issued,
  output logic [STAT_W-1:0] stat_illegal
`endif
);

  issue_entry_t dec_entry;
  issue_entry_t out_q, out_d;
  issue_entry_t skid_q, skid_d;
  logic         out_valid_q, out_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic         accept;

  alu_issue_decode u_decode (
    .instr_i (in_instr),
    .pc_i    (in_pc),
    .rs1_i   (in_rs1_data),
    .rs2_i   (in_rs2_data),
    .entry_o (dec_entry)
  );

  assign accept = in_valid && !skid_valid_q;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      // Output slot frees this edge; an occupied skid blocks accept, so it refills first.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign in_ready    = !skid_valid_q;
  assign out_valid   = out_valid_q;
  assign out_d1      = out_q.d1;
  assign out_d2      = out_q.d2;
  assign out_control = out_q.control;
  assign out_rd      = out_q.rd;
  assign out_wen     = out_q.wen;
  assign out_illegal = out_q.illegal;
  assign out_pc      = out_q.pc;

`ifdef ALU_ISSUE_STATS_EN
  logic              xfer;
  logic [STAT_W-1:0] issued_q, illegal_q;

  assign xfer = out_valid_q && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q  <= '0;
      illegal_q <= '0;
    end else if (xfer) begin
      if (issued_q != '1) issued_q <= issued_q + 1'b1;
      if (out_q.illegal && (illegal_q != '1)) illegal_q <= illegal_q + 1'b1;
    end
  end

  assign stat_issued  = issued_q;
  assign stat_illegal = illegal_q;
`endif

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Front end of the ALU path. Accepts RV32I instructions plus register-file read data over a valid/ready handshake, and decodes opcode/funct3/funct7 into the 4-bit ALU control code and the two operands. Presents the result, registered, to the execute stage through a second valid/ready handshake. A 2-entry skid buffer gives full throughput and a registered in_ready.

Parameters:
XLEN, 32, datapath width for operands, pc and immediates.
STAT_W, 32, width of the optional statistics counters.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  discard all buffered entries (branch redirect).
in_valid  in  1  upstream presents an instruction.
in_ready  out  1  stage can accept an instruction this cycle.
in_instr  in  32  raw instruction word.
in_pc  in  XLEN  instruction address.
in_rs1_data  in  XLEN  register value for instr[19:15].
in_rs2_data  in  XLEN  register value for instr[24:20].
out_valid  out  1  decoded entry available.
out_ready  in  1  execute stage accepts the entry.
out_d1  out  XLEN  ALU operand 1.
out_d2  out  XLEN  ALU operand 2.
out_control  out  4  ALU op code.
out_rd  out  5  destination register.
out_wen  out  1  register writeback enable.
out_illegal  out  1  unsupported or invalid encoding.
out_pc  out  XLEN  pc of the entry.

Behaviour:
- ALU codes (shared package): ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, SRA 1101. All other codes are never emitted.
- OP (0110011):
  - funct7 must be 0000000 or 0100000; any other value is illegal.
  - 0100000 is legal only with funct3 000 (SUB) or 101 (SRA); any other funct3 is illegal.
  - control = {instr[30], funct3}; d1 = rs1_data; d2 = rs2_data.
- OP-IMM (0010011):
  - d1 = rs1_data; d2 = sign-extended I-immediate.
  - control = {0, funct3}, except funct3 101 with instr[30]=1 gives SRA (1101).
  - SLLI requires instr[31:25]=0000000.
  - SRLI/SRAI require instr[31:25] to be 0000000 or 0100000.
  - Any other value is illegal. For ADDI, instr[30] is an immediate bit and is never decoded as SUB.
- LUI (0110111): d1 = 0, d2 = {instr[31:12], 12'b0}, control = ADD.
- AUIPC (0010111): d1 = in_pc, d2 = the U-immediate, control = ADD.
- Any other opcode is illegal.
- Illegal entries: out_illegal = 1, out_wen = 0, control = ADD, d1 = d2 = 0. The entry still flows through the handshake.
- out_wen = legal & (rd != 0).
- Latency: an entry accepted at edge N is visible on out_* after edge N. One entry per cycle in steady state.
- Buffering:
  - Main output register plus one skid register; in_ready = !skid_valid, driven from a flop.
  - When out_valid & !out_ready and a new entry is accepted, the new entry goes to the skid register.
  - When the output drains, skid data moves to the output register in the same edge.
  - out_* remain stable while out_valid & !out_ready.
- Simultaneous accept and drain with an empty skid: the output register loads the new entry and skid stays empty.
- flush: at the edge, both entries are invalidated and any in_valid in the same cycle is dropped. in_ready = 1 on the next cycle. flush overrides both handshakes.
- Reset:
  - out_valid = 0; skid empty; in_ready = 1 after the reset edge.
  - All out_* data outputs = 0, including out_illegal and out_wen.
  - Reset while entries are in flight discards them, with the same effect as flush.

Optional Feature:
ALU_ISSUE_STATS_EN:
- Defined: adds outputs stat_issued[STAT_W-1:0] and stat_illegal[STAT_W-1:0].
  - stat_issued increments on each out_valid & out_ready.
  - stat_illegal increments when that transfer has out_illegal = 1.
  - Both counters saturate at all-ones, reset to 0, and are unaffected by flush.
- Undefined: the ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - alu_op_t, a 4-bit enum with the codes above, shared with the existing ALU.
  - opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC.
  - struct issue_entry_t {d1, d2, control, rd, wen, illegal, pc}.
- Sub-module alu_issue_decode: purely combinational instruction-to-issue_entry_t decoder. The top level holds the skid buffer and handshakes.

Test Plan:
- add x3,x1,x2: 0x002081B3, rs1=5, rs2=7 -> next cycle control=0000, d1=5, d2=7, rd=3, wen=1, illegal=0.
- sub 0x402081B3 -> control=1000. srai x5,x6,3: 0x40335293, rs1=0x80000000 -> control=1101, d2=3, rd=5.
- lui x1,0x12345: 0x123450B7 -> d1=0, d2=0x12345000, control=0000, wen=1. addi x0,x0,0: 0x00000013 -> wen=0.
- 0x00000000, then funct7=0000001 on OP (0x022081B3) -> illegal=1, wen=0, control=0000. Counters (if enabled) are issued=2, illegal=2.
- Back-pressure: stream 4 instructions with out_ready=0 for 3 cycles.
  - in_ready drops after 2 accepts; out_* stay stable while stalled.
  - After release, all 4 emerge in order with no loss or duplication.
- With 2 entries buffered, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, and the dropped instruction never appears.
